sprite_line_fetcher: RTL and testbench
======================================

Name: sprite_line_fetcher

Overview:
- Read-side client of the sprite VRAM (16b x 8 x 4096 banked store: 128-bit sprite line per read address, 12-bit address).
- Accepts one sprite-line request at a time (sprite id, row, horizontal flip).
- Drives the VRAM read address and captures the 128-bit line after the BRAM read latency.
- Streams the line to the sprite renderer as 16 pixels of 8 bits each, with valid/ready backpressure.

Parameters:
- PIX_W, 8, bits per pixel; a 16-bit VRAM word holds one pixel pair.
- PIX_PER_LINE, 16, pixels per sprite line; the line is PIX_W*PIX_PER_LINE = 128 bits.
- ADDR_W, 12, VRAM read address width.
- RD_LAT, 1, VRAM read latency in cycles, counted from the address edge to data valid.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  fetcher can accept a request.
- req_sprite  in  8  sprite index.
- req_row  in  4  row within sprite.
- req_hflip  in  1  emit pixels in reverse order.
- vram_read_addr  out  ADDR_W  address to VRAM, equal to {req_sprite, req_row}.
- vram_read_data  in  PIX_W*PIX_PER_LINE  line data; pair k is bits [16k+15:16k], and its low byte is the even pixel.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  renderer accepts pixel.
- pix_data  out  PIX_W  pixel value.
- pix_idx  out  4  pixel index on screen order, 0..15.
- pix_last  out  1  asserted with pixel 15 of a line.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE, req_ready=1, pix_valid=0, pix_last=0, busy=0.
  - vram_read_addr=0, pix_data=0, pix_idx=0, line register=0, counters=0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: register {sprite,row} into vram_read_addr, register hflip, go to WAIT. req_ready drops on the next cycle.
- WAIT:
  - A latency counter counts RD_LAT cycles while vram_read_addr is held stable.
  - On expiry, capture vram_read_data into the line register and go to SHIFT with pixel counter=0.
  - First pix_valid appears RD_LAT+1 cycles after the accepting edge. With RD_LAT=1: accept at edge N, address visible after N, data captured at N+2, pix_valid high after N+2.
- SHIFT:
  - pix_valid=1.
  - Source byte: byte cnt of the line if hflip=0, byte 15-cnt if hflip=1.
  - pix_idx=cnt. pix_last=(cnt==15).
  - On pix_valid&&pix_ready: cnt increments. When cnt==15 is accepted, go to IDLE.
  - While pix_ready=0, pix_data, pix_idx and pix_last hold stable.
- Output register rules:
  - pix_data, pix_idx and pix_last are registered.
  - No combinational path from pix_ready to pix_valid.
- Throughput, base build: one line per 16 + RD_LAT + 2 cycles at full ready.
- Request handling: a request arriving while req_ready=0 is not consumed, and the requester must hold it.
- Reset mid-line: returns to IDLE immediately. The partially streamed line is discarded and pix_valid drops asynchronously.
- Boundaries:
  - sprite 255 / row 15 gives address 0xFFF.
  - No address arithmetic overflow is possible.

Optional Feature:
- Macro: SPRITE_FETCH_PREFETCH_EN.
- Defined:
  - A second line register is added.
  - req_ready stays high in SHIFT while the second buffer is empty.
  - A request accepted during SHIFT is fetched in the background and captured into the second buffer.
  - After pix_last is accepted, the second buffer swaps into the active register and SHIFT continues with no bubble: the next pixel 0 is valid on the following cycle.
  - req_ready=0 while the second buffer is full or its fetch is in flight.
  - Reset clears both buffers.
- Undefined: single buffer, exactly as specified above.

Decomposition:
- Package sprite_fetch_pkg:
  - Localparams LINE_W=128, PAIRS=8.
  - Enum fetch_state_t {IDLE, WAIT, SHIFT}.
  - Typedef sprite_req_t {sprite[7:0], row[3:0], hflip}.
- One sub-module: sprite_line_serializer, which holds the line register(s), the pixel counter, the hflip byte select and the output handshake.
- The top level keeps the request FSM and the latency counter.

Test Plan:
- Request sprite=0x12 row=0x3 hflip=0, with a VRAM model (RD_LAT=1) whose line has byte b=b+1 -> vram_read_addr=0x123, and pixels 0x01..0x10 appear in order with idx 0..15. pix_last goes high only on 0x10, and the first pix_valid comes 2 cycles after the accept edge.
- Same line with hflip=1 -> pixel sequence 0x10..0x01, pix_idx still 0..15.
- Toggle pix_ready 1,0,0,1 repeatedly -> no pixel lost or duplicated, and outputs stay stable while stalled. Total accepted pixels=16.
- Request sprite=0xFF row=0xF -> address 0xFFF, correct 16-pixel output.
- Assert reset_n low after pixel 7 is accepted -> pix_valid=0 immediately. After release, req_ready=1 and a new request streams a full 16 pixels.
- With SPRITE_FETCH_PREFETCH_EN, issue two back-to-back requests with pix_ready held 1 -> 32 consecutive pix_valid cycles with no gap, second line data correct, and req_ready=0 while the second buffer is full.

Source files
------------

// File: rtl/sprite_line_fetcher_pkg.sv
// Shared types and sizes for the sprite line fetcher.
// Holds the line geometry, the request FSM state encoding, the request payload
// struct and the pixel byte-select helper used by the serializer.
package sprite_fetch_pkg;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned PIX_PER_LINE = 16;
  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned LINE_W       = PIX_W * PIX_PER_LINE;
  localparam int unsigned PAIRS        = LINE_W / (2 * PIX_W);
  localparam int unsigned IDX_W        = 4;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT} fetch_state_t;

  typedef struct packed {
    logic [7:0] sprite;
    logic [3:0] row;
    logic       hflip;
  } sprite_req_t;

  // Pixel idx of a line in screen order; a VRAM word holds an even/odd pixel pair.
  function automatic logic [PIX_W-1:0] pick_pixel(input logic [LINE_W-1:0] line,
                                                  input logic              hflip,
                                                  input logic [IDX_W-1:0]  idx);
    logic [PAIRS-1:0][2*PIX_W-1:0] pairs;
    logic [2*PIX_W-1:0]            pair;
    logic [IDX_W-1:0]              sel;
    pairs = line;
    // 15-idx for a 4-bit index is its bitwise complement
    sel   = hflip ? ~idx : idx;
    pair  = pairs[sel[IDX_W-1:1]];
    return sel[0] ? pair[2*PIX_W-1:PIX_W] : pair[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sprite_line_fetcher_if.sv
// Bundle of the fetcher's request, VRAM read and pixel stream signals.
// master: requester/renderer/VRAM side; slave: the fetcher.
//   req_*          sprite line request handshake (valid/ready)
//   vram_read_*    VRAM read address out, 128-bit line in
//   pix_*          pixel stream handshake (valid/ready) with index and last flag
//   busy           fetcher not idle
interface sprite_line_fetcher_if;
  import sprite_fetch_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [7:0]        req_sprite;
  logic [3:0]        req_row;
  logic              req_hflip;
  logic [ADDR_W-1:0] vram_read_addr;
  logic [LINE_W-1:0] vram_read_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [PIX_W-1:0]  pix_data;
  logic [IDX_W-1:0]  pix_idx;
  logic              pix_last;
  logic              busy;

  modport master (
    output req_valid, req_sprite, req_row, req_hflip, vram_read_data, pix_ready,
    input  req_ready, vram_read_addr, pix_valid, pix_data, pix_idx, pix_last, busy
  );

  modport slave (
    input  req_valid, req_sprite, req_row, req_hflip, vram_read_data, pix_ready,
    output req_ready, vram_read_addr, pix_valid, pix_data, pix_idx, pix_last, busy
  );

endinterface

// File: rtl/sprite_line_fetcher_serializer.sv
// Line register(s), pixel counter, hflip byte select and pixel output handshake.
// Ports: clk, reset_n; load/load_data/load_hflip capture a line from VRAM;
// pix_ready in; pix_valid/pix_data/pix_idx/pix_last registered out;
// line_done_c is high combinationally on the edge pixel 15 is accepted.
// SPRITE_FETCH_PREFETCH_EN adds a second line buffer that swaps in without a bubble.
module sprite_line_serializer
  import sprite_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              load_hflip,
  input  logic              pix_ready,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic [IDX_W-1:0]  pix_idx,
  output logic              pix_last,
  output logic              line_done_c
);

  logic [LINE_W-1:0] line_q, line_n, src_line;
  logic              hflip_q, hflip_n, src_hflip, start;
  logic [IDX_W-1:0]  idx_n;
  logic [PIX_W-1:0]  data_n;
  logic              valid_n, last_n;
`ifdef SPRITE_FETCH_PREFETCH_EN
  logic [LINE_W-1:0] line2_q, line2_n;
  logic              hflip2_q, hflip2_n, full2_q, full2_n;
`endif

  assign line_done_c = pix_valid && pix_ready && (pix_idx == IDX_W'(PIX_PER_LINE - 1));

  // Next pixel selection: advance on handshake, start a new line on load or swap.
  always_comb begin
    line_n    = line_q;
    hflip_n   = hflip_q;
    idx_n     = pix_idx;
    data_n    = pix_data;
    valid_n   = pix_valid;
    last_n    = pix_last;
    start     = 1'b0;
    src_line  = load_data;
    src_hflip = load_hflip;
`ifdef SPRITE_FETCH_PREFETCH_EN
    line2_n   = line2_q;
    hflip2_n  = hflip2_q;
    full2_n   = full2_q;
`endif
    if (line_done_c) begin
      valid_n = 1'b0;
      idx_n   = '0;
      last_n  = 1'b0;
`ifdef SPRITE_FETCH_PREFETCH_EN
      if (full2_q) begin
        start     = 1'b1;
        src_line  = line2_q;
        src_hflip = hflip2_q;
        full2_n   = 1'b0;
      end else
`endif
      if (load) start = 1'b1;
    end else if (pix_valid && pix_ready) begin
      idx_n  = pix_idx + IDX_W'(1);
      last_n = (pix_idx == IDX_W'(PIX_PER_LINE - 2));
      data_n = pick_pixel(line_q, hflip_q, idx_n);
    end else if (load) begin
`ifdef SPRITE_FETCH_PREFETCH_EN
      // A line still streaming means this is the background fetch.
      if (pix_valid) begin
        line2_n  = load_data;
        hflip2_n = load_hflip;
        full2_n  = 1'b1;
      end else
`endif
      start = 1'b1;
    end
    if (start) begin
      line_n  = src_line;
      hflip_n = src_hflip;
      idx_n   = '0;
      valid_n = 1'b1;
      last_n  = 1'b0;
      data_n  = pick_pixel(src_line, src_hflip, '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_q    <= '0;
      hflip_q   <= 1'b0;
      pix_idx   <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
`ifdef SPRITE_FETCH_PREFETCH_EN
      line2_q   <= '0;
      hflip2_q  <= 1'b0;
      full2_q   <= 1'b0;
`endif
    end else begin
      line_q    <= line_n;
      hflip_q   <= hflip_n;
      pix_idx   <= idx_n;
      pix_data  <= data_n;
      pix_valid <= valid_n;
      pix_last  <= last_n;
`ifdef SPRITE_FETCH_PREFETCH_EN
      line2_q   <= line2_n;
      hflip2_q  <= hflip2_n;
      full2_q   <= full2_n;
`endif
    end
  end

endmodule

// File: rtl/sprite_line_fetcher.sv
// Sprite VRAM read client: accepts a sprite-line request, drives the VRAM read
// address, waits out the read latency, and hands the line to the serializer.
// Ports: clk, reset_n (async active-low), bus (sprite_line_fetcher_if.slave).
// Parameter RD_LAT: VRAM read latency in cycles from address edge to data valid.
// Build option SPRITE_FETCH_PREFETCH_EN: accept the next request while streaming
// and fetch it in the background into a second line buffer.
module sprite_line_fetcher
  import sprite_fetch_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sprite_line_fetcher_if.slave  bus
);

  localparam int unsigned LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  fetch_state_t state, state_n;
  logic [LAT_W-1:0] lat_cnt, lat_n;
  sprite_req_t      fetch_req, fetch_req_n;
  logic             req_ready_q, req_ready_n, busy_q, busy_n;
  logic             accept_c, expire_c, in_flight_c, line_done_c;
`ifdef SPRITE_FETCH_PREFETCH_EN
  logic             fetching, fetching_n, pend, pend_n;
`endif

  assign bus.req_ready      = req_ready_q;
  assign bus.busy           = busy_q;
  assign bus.vram_read_addr = {fetch_req.sprite, fetch_req.row};

  // Next state, fetch address and latency count.
  always_comb begin
    state_n     = state;
    lat_n       = lat_cnt;
    fetch_req_n = fetch_req;
    accept_c    = bus.req_valid && req_ready_q;
`ifdef SPRITE_FETCH_PREFETCH_EN
    fetching_n  = fetching;
    pend_n      = pend;
    in_flight_c = fetching;
`else
    in_flight_c = (state == WAIT);
`endif
    // One extra cycle past RD_LAT so data is captured a full cycle after it lands.
    expire_c = in_flight_c && (lat_cnt == LAT_W'(RD_LAT));
    if (in_flight_c && !expire_c) lat_n = lat_cnt + LAT_W'(1);
    if (accept_c) begin
      fetch_req_n = '{sprite: bus.req_sprite, row: bus.req_row, hflip: bus.req_hflip};
      lat_n       = '0;
    end
    case (state)
      IDLE:  if (accept_c) state_n = WAIT;
      WAIT:  if (expire_c) state_n = SHIFT;
      SHIFT: begin
        if (line_done_c) begin
`ifdef SPRITE_FETCH_PREFETCH_EN
          if (pend) begin
            pend_n = 1'b0;
            // Background fetch not back yet: wait for it with nothing streaming.
            if (fetching && !expire_c) state_n = WAIT;
          end else begin
            state_n = accept_c ? WAIT : IDLE;
          end
`else
          state_n = IDLE;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef SPRITE_FETCH_PREFETCH_EN
    if (accept_c) fetching_n = 1'b1;
    else if (expire_c) fetching_n = 1'b0;
    if (accept_c && (state == SHIFT) && !line_done_c) pend_n = 1'b1;
`endif
    req_ready_n = (state_n == IDLE);
`ifdef SPRITE_FETCH_PREFETCH_EN
    if ((state_n == SHIFT) && !pend_n && !fetching_n) req_ready_n = 1'b1;
`endif
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      fetch_req   <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef SPRITE_FETCH_PREFETCH_EN
      fetching    <= 1'b0;
      pend        <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      lat_cnt     <= lat_n;
      fetch_req   <= fetch_req_n;
      req_ready_q <= req_ready_n;
      busy_q      <= busy_n;
`ifdef SPRITE_FETCH_PREFETCH_EN
      fetching    <= fetching_n;
      pend        <= pend_n;
`endif
    end
  end

  sprite_line_serializer u_ser (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (expire_c),
    .load_data   (bus.vram_read_data),
    .load_hflip  (fetch_req.hflip),
    .pix_ready   (bus.pix_ready),
    .pix_valid   (bus.pix_valid),
    .pix_data    (bus.pix_data),
    .pix_idx     (bus.pix_idx),
    .pix_last    (bus.pix_last),
    .line_done_c (line_done_c)
  );

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Testbench for sprite_line_fetcher: VRAM model with one cycle read latency,
// pixel scoreboard built from the line contents, table of directed requests,
// hand-written latency/reset/back-to-back sequences and randomized traffic.
module tb_sprite_line_fetcher;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sprite_line_fetcher_if bus ();

  sprite_line_fetcher #(.RD_LAT(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

`ifdef SPRITE_FETCH_PREFETCH_EN
  localparam logic PF = 1'b1;
`else
  localparam logic PF = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic [3:0] idx;
    logic       last;
  } pix_t;

  typedef struct {
    logic [7:0]  sprite;
    logic [3:0]  row;
    logic        hflip;
    int          rdy_mode;
    logic [11:0] exp_addr;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   px_count = 0;
  int   rdy_mode = 0;
  int   cyc = 0;
  pix_t exp_q[$];
  pix_t e;
  logic [7:0] first_pix, last_pix;
  logic       stall_prev = 1'b0;
  logic [7:0] hold_data;
  logic [3:0] hold_idx;
  logic       hold_last;

  // Byte b of the sprite line stored at address a.
  function automatic logic [7:0] model_byte(input logic [11:0] a, input int b);
    if (a == 12'h123) return 8'(b + 1);
    return 8'(int'(a[11:4]) + int'(a[3:0]) + 16 * b);
  endfunction

  function automatic logic [127:0] vram_line(input logic [11:0] a);
    logic [127:0] l;
    for (int b = 0; b < 16; b++) l[8*b +: 8] = model_byte(a, b);
    return l;
  endfunction

  // Screen-order pixels a request must produce.
  function automatic void push_line(input logic [11:0] a, input logic h);
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{data: model_byte(a, h ? 15 - i : i), idx: 4'(i), last: (i == 15)});
  endfunction

  always @(posedge clk) bus.vram_read_data <= vram_line(bus.vram_read_addr);

  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0:       bus.pix_ready = 1'b1;
      1:       bus.pix_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: bus.pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (bus.pix_valid !== 1'b1 || bus.pix_data !== hold_data ||
            bus.pix_idx !== hold_idx || bus.pix_last !== hold_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%02h i=%0d l=%0b, expected v=1 d=%02h i=%0d l=%0b",
                   bus.pix_valid, bus.pix_data, bus.pix_idx, bus.pix_last, hold_data, hold_idx, hold_last);
        end
      end
      if (bus.pix_valid && bus.pix_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_pixel: got d=%02h i=%0d, expected no pixel", bus.pix_data, bus.pix_idx);
        end else begin
          e = exp_q.pop_front();
          if (bus.pix_data !== e.data || bus.pix_idx !== e.idx || bus.pix_last !== e.last) begin
            errors++;
            $display("FAIL pixel: got d=%02h i=%0d l=%0b, expected d=%02h i=%0d l=%0b",
                     bus.pix_data, bus.pix_idx, bus.pix_last, e.data, e.idx, e.last);
          end
        end
        if (bus.pix_idx == 4'd0) first_pix = bus.pix_data;
        if (bus.pix_idx == 4'd15) last_pix = bus.pix_data;
        px_count++;
      end
      stall_prev = bus.pix_valid && !bus.pix_ready;
      hold_data  = bus.pix_data;
      hold_idx   = bus.pix_idx;
      hold_last  = bus.pix_last;
      if (bus.req_valid && bus.req_ready) push_line({bus.req_sprite, bus.req_row}, bus.req_hflip);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Present a request and hold it until accepted; returns just after the accepting edge.
  task automatic issue_req(input logic [7:0] s, input logic [3:0] r, input logic h);
    logic ok;
    bus.req_valid  = 1'b1;
    bus.req_sprite = s;
    bus.req_row    = r;
    bus.req_hflip  = h;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("req_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_pixels(input int target);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (px_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    chk("pixel_wait", 32'(ok), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   start, run;
    vecs[0] = '{8'h12, 4'h3, 1'b0, 0, 12'h123, 8'h01, 8'h10};
    vecs[1] = '{8'h12, 4'h3, 1'b1, 0, 12'h123, 8'h10, 8'h01};
    vecs[2] = '{8'h12, 4'h3, 1'b0, 1, 12'h123, 8'h01, 8'h10};
    vecs[3] = '{8'hFF, 4'hF, 1'b0, 0, 12'hFFF, 8'h0E, 8'hFE};
    vecs[4] = '{8'h00, 4'h0, 1'b1, 1, 12'h000, 8'hF0, 8'h00};

    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_sprite = '0;
    bus.req_row    = '0;
    bus.req_hflip  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    chk("rst_pix_last",  32'(bus.pix_last),  32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_addr",      32'(bus.vram_read_addr), 32'd0);
    chk("rst_pix_data",  32'(bus.pix_data),  32'd0);
    chk("rst_pix_idx",   32'(bus.pix_idx),   32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed lines: address, first-valid latency, content and count.
    for (int v = 0; v < 5; v++) begin
      rdy_mode = vecs[v].rdy_mode;
      start = px_count;
      issue_req(vecs[v].sprite, vecs[v].row, vecs[v].hflip);
      chk("vram_addr", 32'(bus.vram_read_addr), 32'(vecs[v].exp_addr));
      @(negedge clk);
      chk("lat0_valid", 32'(bus.pix_valid), 32'd0);
      chk("lat0_busy",  32'(bus.busy), 32'd1);
      chk("lat0_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      chk("lat1_valid", 32'(bus.pix_valid), 32'd0);
      @(negedge clk);
      chk("lat2_valid", 32'(bus.pix_valid), 32'd1);
      wait_pixels(start + 16);
      repeat (4) @(posedge clk);
      #1;
      chk("line_px_count", 32'(px_count - start), 32'd16);
      chk("line_first_pix", 32'(first_pix), 32'(vecs[v].exp_first));
      chk("line_last_pix",  32'(last_pix),  32'(vecs[v].exp_last));
      chk("line_end_valid", 32'(bus.pix_valid), 32'd0);
      chk("line_end_busy",  32'(bus.busy), 32'd0);
    end

    // Reset after pixel 7 is accepted.
    rdy_mode = 0;
    start = px_count;
    issue_req(8'h34, 4'h5, 1'b0);
    wait_pixels(start + 8);
    chk("pre_reset_valid", 32'(bus.pix_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_valid", 32'(bus.pix_valid), 32'd0);
    chk("mid_reset_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_reset_busy",  32'(bus.busy), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ready", 32'(bus.req_ready), 32'd1);
    start = px_count;
    issue_req(8'h56, 4'h7, 1'b1);
    wait_pixels(start + 16);
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_px", 32'(px_count - start), 32'd16);

    // Back-to-back requests at full ready.
    start = px_count;
    issue_req(8'hA5, 4'h2, 1'b0);
    fork
      issue_req(8'h3C, 4'h9, 1'b1);
      begin
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (bus.pix_valid) begin
            seen = 1'b1;
            break;
          end
        end
        chk("b2b_first_valid", 32'(seen), 32'd1);
        run = 1;
        for (int k = 1; k < 32; k++) begin
          @(negedge clk);
          if (bus.pix_valid) run++;
          if (k == 8) chk("b2b_ready_while_full", 32'(bus.req_ready), 32'd0);
          if (k == 16) chk("b2b_boundary_valid", 32'(bus.pix_valid), 32'(PF));
        end
`ifdef SPRITE_FETCH_PREFETCH_EN
        chk("b2b_consecutive_valid", 32'(run), 32'd32);
`endif
      end
    join
    wait_pixels(start + 32);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_px_count", 32'(px_count - start), 32'd32);

    // Randomized requests and backpressure against the scoreboard.
    rdy_mode = 2;
    for (int n = 0; n < 20; n++) begin
      issue_req(8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    #1;
    chk("random_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
